// File: rtl/seg7_pkg.sv
// Shared segment encodings and FSM state type for the 7-segment readback monitor.
// Segment patterns are written abcdefg, active-low, matching a [0:6] bus.
package seg7_pkg;

   typedef logic [0:6] seg_t;

   localparam seg_t SEG_HEX_0 = 7'b0000001;
   localparam seg_t SEG_HEX_1 = 7'b1001111;
   localparam seg_t SEG_HEX_2 = 7'b0010010;
   localparam seg_t SEG_HEX_3 = 7'b0000110;
   localparam seg_t SEG_HEX_4 = 7'b1001100;
   localparam seg_t SEG_HEX_5 = 7'b0100100;
   localparam seg_t SEG_HEX_6 = 7'b0100000;
   localparam seg_t SEG_HEX_7 = 7'b0001111;
   localparam seg_t SEG_HEX_8 = 7'b0000000;
   localparam seg_t SEG_HEX_9 = 7'b0001100;
   localparam seg_t SEG_HEX_A = 7'b0001000;
   localparam seg_t SEG_HEX_B = 7'b1100000;
   localparam seg_t SEG_HEX_C = 7'b0110001;
   localparam seg_t SEG_HEX_D = 7'b1000010;
   localparam seg_t SEG_HEX_E = 7'b0110000;
   localparam seg_t SEG_HEX_F = 7'b0111000;

   localparam seg_t SEG_BLANK = 7'b1111111;

   typedef enum logic {
      SCAN,
      COMMIT
   } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment pattern to nibble decoder; unknown patterns
// decode to 0 with invalid raised.
module seg7_to_hex
   import seg7_pkg::*;
(
   input  seg_t       seg,
   output logic [3:0] nibble,
   output logic       invalid
);

   always_comb begin
      nibble  = 4'h0;
      invalid = 1'b0;
      case (seg)
         SEG_HEX_0: nibble = 4'h0;
         SEG_HEX_1: nibble = 4'h1;
         SEG_HEX_2: nibble = 4'h2;
         SEG_HEX_3: nibble = 4'h3;
         SEG_HEX_4: nibble = 4'h4;
         SEG_HEX_5: nibble = 4'h5;
         SEG_HEX_6: nibble = 4'h6;
         SEG_HEX_7: nibble = 4'h7;
         SEG_HEX_8: nibble = 4'h8;
         SEG_HEX_9: nibble = 4'h9;
         SEG_HEX_A: nibble = 4'hA;
         SEG_HEX_B: nibble = 4'hB;
         SEG_HEX_C: nibble = 4'hC;
         SEG_HEX_D: nibble = 4'hD;
         SEG_HEX_E: nibble = 4'hE;
         SEG_HEX_F: nibble = 4'hF;
         default:   invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_capture.sv
// Rebuilds the 16-bit hex value shown on a scanned 4-digit active-low 7-segment bus.
// Optional SEG7_CAPTURE_BLANK_EN: all-off digits are legal blanks reported on BLANK.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [0:6]  SEG,
   input  logic [3:0]  DIG,
   output logic [15:0] VALUE,
   output logic        VALID,
   output logic [3:0]  ERR,
   output logic        TMO
`ifdef SEG7_CAPTURE_BLANK_EN
   ,
   output logic [3:0]  BLANK
`endif
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CMAX  = CW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   seg_t          seg_q, seg_p;
   logic [3:0]    dig_q, dig_p;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accepted_q, accepted_d;
   logic [3:0]    seen_q, seen_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [15:0]   slot_q;
   logic [3:0]    errslot_q;
   state_t        state_q, state_d;

   logic          onehot, same, accept;
   logic          tmo_hit, commit, do_write;
   logic [3:0]    nibble;
   logic          invalid, err_bit;

   seg7_to_hex u_dec (
      .seg     (seg_q),
      .nibble  (nibble),
      .invalid (invalid)
   );

`ifdef SEG7_CAPTURE_BLANK_EN
   logic       is_blank;
   logic [3:0] blankslot_q;
   assign is_blank = (seg_q == SEG_BLANK);
   assign err_bit  = invalid & ~is_blank;
`else
   assign err_bit  = invalid;
`endif

   assign onehot = $onehot(dig_q);
   assign same   = (seg_q == seg_p) && (dig_q == dig_p);

   // Unified accept rule: with STABLE_CYCLES=1 the first one-hot sample accepts
   // even when it differs from the previous one.
   always_comb begin
      cnt_d      = '0;
      accepted_d = 1'b0;
      accept     = 1'b0;
      if (same && onehot) begin
         cnt_d      = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
         accepted_d = accepted_q;
      end
      if (onehot && !accepted_d && (cnt_d == CMAX)) begin
         accept     = 1'b1;
         accepted_d = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      seen_d   = seen_q;
      tcnt_d   = tcnt_q;
      tmo_hit  = 1'b0;
      commit   = 1'b0;
      do_write = 1'b0;
      case (state_q)
         SCAN: begin
            if (seen_q != 4'b0000) begin
               if (tcnt_q == TLAST) tmo_hit = 1'b1;
               else                 tcnt_d  = tcnt_q + 1'b1;
            end else begin
               tcnt_d = '0;
            end
            // A timeout on the same edge as an accept discards that accept too.
            if (tmo_hit) begin
               seen_d = '0;
               tcnt_d = '0;
            end else if (accept) begin
               seen_d   = seen_q | dig_q;
               do_write = 1'b1;
               if ((seen_q | dig_q) == 4'b1111) state_d = COMMIT;
            end
         end
         COMMIT: begin
            commit   = 1'b1;
            tcnt_d   = '0;
            seen_d   = accept ? dig_q : 4'b0000;
            do_write = accept;
            state_d  = SCAN;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) state_q <= SCAN;
      else       state_q <= state_d;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         seg_q       <= SEG_BLANK;
         seg_p       <= SEG_BLANK;
         dig_q       <= '0;
         dig_p       <= '0;
         cnt_q       <= '0;
         accepted_q  <= 1'b0;
         seen_q      <= '0;
         tcnt_q      <= '0;
         slot_q      <= '0;
         errslot_q   <= '0;
         VALUE       <= '0;
         VALID       <= 1'b0;
         ERR         <= '0;
         TMO         <= 1'b0;
`ifdef SEG7_CAPTURE_BLANK_EN
         blankslot_q <= '0;
         BLANK       <= '0;
`endif
      end else begin
         seg_q      <= SEG;
         dig_q      <= DIG;
         seg_p      <= seg_q;
         dig_p      <= dig_q;
         cnt_q      <= cnt_d;
         accepted_q <= accepted_d;
         seen_q     <= seen_d;
         tcnt_q     <= tcnt_d;
         VALID      <= commit;
         TMO        <= tmo_hit;
         if (commit) begin
            VALUE <= slot_q;
            ERR   <= errslot_q;
`ifdef SEG7_CAPTURE_BLANK_EN
            BLANK <= blankslot_q;
`endif
         end
         if (do_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
               if (dig_q[i]) begin
                  slot_q[4*i +: 4] <= nibble;
                  errslot_q[i]     <= err_bit;
`ifdef SEG7_CAPTURE_BLANK_EN
                  blankslot_q[i]   <= is_blank;
`endif
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: expected frames are queued as stimulus is
// driven and matched against frames captured whenever VALID pulses.
module tb_seg7_capture;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [0:6]  SEG;
   logic [3:0]  DIG;
   logic [15:0] VALUE;
   logic        VALID;
   logic [3:0]  ERR;
   logic        TMO;
`ifdef SEG7_CAPTURE_BLANK_EN
   logic [3:0]  BLANK;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int valid_cnt   = 0;
   int tmo_cnt     = 0;

   logic [19:0] exp_q[$];
   logic [19:0] obs_q[$];

   seg7_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .SEG   (SEG),
      .DIG   (DIG),
      .VALUE (VALUE),
      .VALID (VALID),
      .ERR   (ERR),
      .TMO   (TMO)
`ifdef SEG7_CAPTURE_BLANK_EN
      ,
      .BLANK (BLANK)
`endif
   );

   always #5 Clock = ~Clock;

   always @(negedge Clock) begin
      if (Reset === 1'b0) begin
         if (VALID === 1'b1) begin
            valid_cnt++;
            obs_q.push_back({VALUE, ERR});
         end
         if (TMO === 1'b1) tmo_cnt++;
      end
   end

   function automatic logic [0:6] pat(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0001100;
         4'hA: return 7'b0001000;
         4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;
         4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge Clock);
         #1;
      end
   endtask

   task automatic idle(input int n);
      DIG = 4'b0000;
      SEG = 7'b1111111;
      cyc(n);
   endtask

   task automatic send_digit(input int idx, input logic [0:6] p, input int hold);
      DIG = 4'(1 << idx);
      SEG = p;
      cyc(hold);
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         SEG = 7'($urandom);
         DIG = 4'($urandom);
         @(negedge Clock);
         vectors++;
         if (VALUE !== 16'h0000) begin miscompares++; $display("FAIL reset_value got %h want 0000", VALUE); end
         vectors++;
         if (VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", VALID); end
         vectors++;
         if (ERR !== 4'b0000) begin miscompares++; $display("FAIL reset_err got %b want 0000", ERR); end
         vectors++;
         if (TMO !== 1'b0) begin miscompares++; $display("FAIL reset_tmo got %b want 0", TMO); end
      end
      #1;
      Reset = 1'b0;
      idle(10);
      vectors++;
      if (valid_cnt !== 0 || tmo_cnt !== 0) begin
         miscompares++;
         $display("FAIL post_reset_quiet valid=%0d tmo=%0d want 0/0", valid_cnt, tmo_cnt);
      end
   endtask

   task automatic test_full_frame;
      logic [19:0] e, o;
      int v0;
      v0 = valid_cnt;
      exp_q.push_back({16'h1234, 4'b0000});
      send_digit(3, pat(4'h1), 8);
      send_digit(2, pat(4'h2), 8);
      send_digit(1, pat(4'h3), 8);
      DIG = 4'b0001;
      SEG = pat(4'h4);
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         vectors++;
         if (VALID !== (k == 6)) begin
            miscompares++;
            $display("FAIL latency_valid edge %0d got %b want %b", k, VALID, (k == 6));
         end
      end
      idle(3);
      vectors++;
      if (valid_cnt - v0 != 1 || obs_q.size() != 1) begin
         miscompares++;
         $display("FAIL full_frame_count valid=%0d queued=%0d want 1/1", valid_cnt - v0, obs_q.size());
      end
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o !== e) begin miscompares++; $display("FAIL full_frame got %h/%b want %h/%b", o[19:4], o[3:0], e[19:4], e[3:0]); end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_glitch;
      logic [19:0] e, o;
      int v0, t0;
      v0 = valid_cnt;
      t0 = tmo_cnt;
      send_digit(0, pat(4'hA), 3);
      DIG = 4'b0011;
      cyc(20);
      idle(70);
      vectors++;
      if (tmo_cnt != t0 || valid_cnt != v0) begin
         miscompares++;
         $display("FAIL glitch_no_accept tmo=%0d valid=%0d want %0d/%0d", tmo_cnt, valid_cnt, t0, v0);
      end
      exp_q.push_back({16'hABCD, 4'b0000});
      send_digit(3, pat(4'hA), 8);
      send_digit(2, pat(4'hB), 8);
      send_digit(1, pat(4'hC), 8);
      send_digit(0, pat(4'hD), 8);
      idle(3);
      vectors++;
      if (obs_q.size() != 1) begin miscompares++; $display("FAIL glitch_frame_count got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o !== e) begin miscompares++; $display("FAIL glitch_frame got %h/%b want %h/%b", o[19:4], o[3:0], e[19:4], e[3:0]); end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_invalid;
      logic [19:0] e, o;
      exp_q.push_back({16'h8F09, 4'b0010});
      send_digit(3, pat(4'h8), 8);
      send_digit(2, pat(4'hF), 8);
      send_digit(1, 7'b1111110, 8);
      send_digit(0, pat(4'h9), 8);
      idle(3);
      vectors++;
      if (obs_q.size() != 1) begin miscompares++; $display("FAIL invalid_count got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o !== e) begin miscompares++; $display("FAIL invalid_frame got %h/%b want %h/%b", o[19:4], o[3:0], e[19:4], e[3:0]); end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_timeout_overwrite;
      logic [19:0] e, o;
      int v0, t0, hit;
      v0  = valid_cnt;
      t0  = tmo_cnt;
      hit = -1;
      send_digit(3, pat(4'h1), 8);
      send_digit(2, pat(4'h2), 8);
      send_digit(1, pat(4'h3), 8);
      DIG = 4'b0000;
      SEG = 7'b1111111;
      // First accept lands on edge 5 of digit 3; TMO is registered 64 edges later.
      for (int k = 25; k <= 120 && hit < 0; k++) begin
         cyc(1);
         if (TMO === 1'b1) hit = k;
      end
      vectors++;
      if (hit != 69) begin miscompares++; $display("FAIL tmo_timing got edge %0d want 69", hit); end
      idle(2);
      vectors++;
      if (tmo_cnt - t0 != 1 || valid_cnt != v0) begin
         miscompares++;
         $display("FAIL tmo_pulse tmo=%0d valid=%0d want 1/0", tmo_cnt - t0, valid_cnt - v0);
      end
      vectors++;
      if (VALUE !== 16'h8F09 || ERR !== 4'b0010) begin
         miscompares++;
         $display("FAIL tmo_hold got %h/%b want 8f09/0010", VALUE, ERR);
      end
      exp_q.push_back({16'h6E07, 4'b0000});
      send_digit(0, pat(4'h5), 8);
      send_digit(0, pat(4'h7), 8);
      send_digit(3, pat(4'h6), 8);
      send_digit(2, pat(4'hE), 8);
      send_digit(1, pat(4'h0), 8);
      idle(3);
      vectors++;
      if (obs_q.size() != 1) begin miscompares++; $display("FAIL overwrite_count got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o !== e) begin miscompares++; $display("FAIL overwrite_frame got %h/%b want %h/%b", o[19:4], o[3:0], e[19:4], e[3:0]); end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_midframe_reset;
      int v0, t0;
      send_digit(3, pat(4'h1), 8);
      send_digit(2, pat(4'h2), 8);
      Reset = 1'b1;
      cyc(1);
      vectors++;
      if (VALUE !== 16'h0000 || VALID !== 1'b0 || ERR !== 4'b0000 || TMO !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_outputs got %h/%b/%b/%b want 0000/0/0000/0", VALUE, VALID, ERR, TMO);
      end
      Reset = 1'b0;
      v0 = valid_cnt;
      t0 = tmo_cnt;
      send_digit(1, pat(4'h3), 8);
      send_digit(0, pat(4'h4), 8);
      idle(20);
      vectors++;
      if (valid_cnt != v0) begin miscompares++; $display("FAIL midreset_no_valid got %0d want 0", valid_cnt - v0); end
      idle(70);
      vectors++;
      if (tmo_cnt - t0 != 1 || valid_cnt != v0) begin
         miscompares++;
         $display("FAIL midreset_tmo tmo=%0d valid=%0d want 1/0", tmo_cnt - t0, valid_cnt - v0);
      end
      obs_q.delete();
   endtask

   task automatic test_blank;
      logic [19:0] e, o;
`ifdef SEG7_CAPTURE_BLANK_EN
      exp_q.push_back({16'h0123, 4'b0000});
`else
      exp_q.push_back({16'h0123, 4'b1000});
`endif
      send_digit(3, 7'b1111111, 8);
      send_digit(2, pat(4'h1), 8);
      send_digit(1, pat(4'h2), 8);
      send_digit(0, pat(4'h3), 8);
      idle(3);
      vectors++;
      if (obs_q.size() != 1) begin miscompares++; $display("FAIL blank_count got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o !== e) begin miscompares++; $display("FAIL blank_frame got %h/%b want %h/%b", o[19:4], o[3:0], e[19:4], e[3:0]); end
      end
`ifdef SEG7_CAPTURE_BLANK_EN
      vectors++;
      if (BLANK !== 4'b1000) begin miscompares++; $display("FAIL blank_mask got %b want 1000", BLANK); end
`endif
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      SEG   = 7'b1111111;
      DIG   = 4'b0000;
      Reset = 1'b1;
      test_reset();
      test_full_frame();
      test_glitch();
      test_invalid();
      test_timeout_overwrite();
      test_midframe_reset();
      test_blank();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
